// File: rtl/dpram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dpram_arbiter_pkg
// Description : Shared defaults, grant record and helpers for dpram_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dpram_arbiter_pkg;

    localparam int c_def_num_req    = 4;
    localparam int c_def_data_width = 64;
    localparam int c_def_addr_width = 6;

    // Requester indices are carried at the width of the largest supported count.
    localparam int c_max_req = 8;
    localparam int c_idx_w   = 3;

    localparam int                   c_stall_w   = 16;
    localparam logic [c_stall_w-1:0] c_stall_max = '1;

    typedef logic [c_idx_w-1:0] req_idx_t;

    typedef struct packed {
        logic     vld;
        req_idx_t idx;
    } grant_t;

    // (base + k) mod n, valid for base < n and k < n.
    function automatic req_idx_t wrap_idx(input req_idx_t base, input int k, input int n);
        int s;
        s = int'(base) + k;
        if (s >= n) begin
            s = s - n;
        end
        return req_idx_t'(s);
    endfunction

    function automatic logic [c_stall_w-1:0] sat_inc(input logic [c_stall_w-1:0] v);
        return (v == c_stall_max) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dpram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dpram_arbiter_if
// Description : Packed multi-requester request/response bus for dpram_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface dpram_arbiter_if
    import dpram_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = c_def_num_req,
    parameter int DATA_WIDTH = c_def_data_width,
    parameter int ADDR_WIDTH = c_def_addr_width
);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_wen;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface
`default_nettype wire

// File: rtl/dpram_arbiter_dpram.sv
`default_nettype none
// ============================================================================
// Module      : dpram_arbiter_dpram
// Description : True dual-port RAM, read-first on both ports, registered q.
// Revision    : 1.0 - initial release
// ============================================================================
module dpram_arbiter_dpram
    import dpram_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = c_def_data_width,
    parameter int ADDR_WIDTH = c_def_addr_width
) (
    input  logic                  clk,
    input  logic                  a_wen,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic [DATA_WIDTH-1:0] a_q,
    input  logic                  b_wen,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic [DATA_WIDTH-1:0] b_q
);

    localparam int c_depth = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [0:c_depth-1];
    logic [DATA_WIDTH-1:0] r_a_q;
    logic [DATA_WIDTH-1:0] r_b_q;

    // Contents are deliberately never reset; q returns the word before any write.
    always_ff @(posedge clk) begin
        if (a_wen) begin
            r_mem[a_addr] <= a_wdata;
        end
        if (b_wen) begin
            r_mem[b_addr] <= b_wdata;
        end
        r_a_q <= r_mem[a_addr];
        r_b_q <= r_mem[b_addr];
    end

    assign a_q = r_a_q;
    assign b_q = r_b_q;

endmodule
`default_nettype wire

// File: rtl/dpram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dpram_arbiter
// Description : Round-robin mapping of up to two requests per cycle onto a DPRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module dpram_arbiter
    import dpram_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = c_def_num_req,
    parameter int DATA_WIDTH = c_def_data_width,
    parameter int ADDR_WIDTH = c_def_addr_width
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dpram_arbiter_if.slave       bus,
    output logic [c_stall_w-1:0] stall_cnt
);

    logic [c_max_req-1:0]  w_valid;
    logic [c_max_req-1:0]  w_wen;
    logic [ADDR_WIDTH-1:0] w_addr  [c_max_req];
    logic [DATA_WIDTH-1:0] w_wdata [c_max_req];

    grant_t                w_a;
    grant_t                w_b;
    logic                  w_conflict;
    logic [NUM_REQ-1:0]    w_ready;
    logic [DATA_WIDTH-1:0] w_q_a;
    logic [DATA_WIDTH-1:0] w_q_b;

    req_idx_t              r_rr_ptr;
    grant_t                r_a;
    grant_t                r_b;
    logic [NUM_REQ-1:0]    r_rsp_valid;
    logic [c_stall_w-1:0]  r_stall_cnt;

    // Pad requesters out to the index width so lookups never go out of range.
    for (genvar i = 0; i < c_max_req; i++) begin : g_unpack
        if (i < NUM_REQ) begin : g_live
            assign w_valid[i] = bus.req_valid[i];
            assign w_wen[i]   = bus.req_wen[i];
            assign w_addr[i]  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_wdata[i] = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_pad
            assign w_valid[i] = 1'b0;
            assign w_wen[i]   = 1'b0;
            assign w_addr[i]  = '0;
            assign w_wdata[i] = '0;
        end
    end

    always_comb begin
        req_idx_t cand;
        int       a_off;
        logic     b_done;
        w_a        = '0;
        w_b        = '0;
        w_conflict = 1'b0;
        cand       = '0;
        a_off      = 0;
        b_done     = 1'b0;
        if (rst_n) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = wrap_idx(r_rr_ptr, k, NUM_REQ);
                if (!w_a.vld && w_valid[cand]) begin
                    w_a.vld = 1'b1;
                    w_a.idx = cand;
                    a_off   = k;
                end
            end
            // Only the first candidate after the port-A winner is considered.
            for (int k = 1; k < NUM_REQ; k++) begin
                cand = wrap_idx(r_rr_ptr, k, NUM_REQ);
                if (w_a.vld && !b_done && (k > a_off) && w_valid[cand]) begin
                    b_done = 1'b1;
                    if ((w_addr[cand] == w_addr[w_a.idx]) && (w_wen[cand] || w_wen[w_a.idx])) begin
                        w_conflict = 1'b1;
                    end else begin
                        w_b.vld = 1'b1;
                        w_b.idx = cand;
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_ready
        assign w_ready[i] = (w_a.vld && (w_a.idx == req_idx_t'(i))) ||
                            (w_b.vld && (w_b.idx == req_idx_t'(i)));
    end

    assign bus.req_ready = w_ready;

    dpram_arbiter_dpram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_dpram (
        .clk     (clk),
        .a_wen   (w_a.vld & w_wen[w_a.idx]),
        .a_addr  (w_addr[w_a.idx]),
        .a_wdata (w_wdata[w_a.idx]),
        .a_q     (w_q_a),
        .b_wen   (w_b.vld & w_wen[w_b.idx]),
        .b_addr  (w_addr[w_b.idx]),
        .b_wdata (w_wdata[w_b.idx]),
        .b_q     (w_q_b)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_rsp_valid <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_a         <= w_a;
            r_b         <= w_b;
            r_rsp_valid <= w_ready;
            if (w_b.vld) begin
                r_rr_ptr <= wrap_idx(w_b.idx, 1, NUM_REQ);
            end else if (w_a.vld) begin
                r_rr_ptr <= wrap_idx(w_a.idx, 1, NUM_REQ);
            end
            if (w_conflict) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
        end
    end

    // Responses are masked while in reset so an in-flight one never escapes.
    assign bus.rsp_valid = rst_n ? r_rsp_valid : '0;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
        assign bus.rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] =
            !rst_n                                       ? '0    :
            (r_a.vld && (r_a.idx == req_idx_t'(i)))      ? w_q_a :
            (r_b.vld && (r_b.idx == req_idx_t'(i)))      ? w_q_b : '0;
    end

    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dpram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dpram_arbiter
// Description : Directed table-driven bench for dpram_arbiter (4 requesters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dpram_arbiter;
    import dpram_arbiter_pkg::*;

    localparam int NR = 4;
    localparam int DW = 64;
    localparam int AW = 6;

    typedef struct packed {
        logic [3:0]      valid;
        logic [3:0]      wen;
        logic [3:0][5:0] addr;
        logic [3:0][7:0] wdata;
        logic [3:0]      exp_ready;
        logic [3:0]      exp_rsp;
        logic [3:0]      chk_rd;
        logic [3:0][7:0] exp_rd;
        logic [15:0]     exp_stall;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] stall_cnt;
    int          n_checks = 0;
    int          n_fail   = 0;
    vec_t        vecs[$];

    dpram_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dpram_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] w,
                         input logic [3:0][5:0] a, input logic [3:0][7:0] d);
        bus.req_valid = v;
        bus.req_wen   = w;
        for (int i = 0; i < NR; i++) begin
            bus.req_addr[i*AW +: AW]  = a[i];
            bus.req_wdata[i*DW +: DW] = 64'(d[i]);
        end
    endtask

    function automatic logic [63:0] rdata(input int i);
        return bus.rsp_rdata[i*DW +: DW];
    endfunction

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] w,
                                input logic [3:0][5:0] a, input logic [3:0][7:0] d,
                                input logic [3:0] er, input logic [3:0] ersp,
                                input logic [3:0] chkm, input logic [3:0][7:0] erd,
                                input logic [15:0] es);
        vec_t t;
        t.valid = v;  t.wen = w;  t.addr = a;  t.wdata = d;
        t.exp_ready = er;  t.exp_rsp = ersp;  t.chk_rd = chkm;
        t.exp_rd = erd;  t.exp_stall = es;
        return t;
    endfunction

    initial begin
        // Each row: inputs for one cycle; responses expected are those of the previous row.
        vecs.push_back(mk(4'b0001, 4'b0001, {6'd0,6'd0,6'd0,6'd5}, {8'h0,8'h0,8'h0,8'hAA}, 4'b0001, 4'b0000, 4'b0000, '0, 16'd0));
        vecs.push_back(mk(4'b0010, 4'b0000, {6'd0,6'd0,6'd5,6'd0}, '0,                     4'b0010, 4'b0001, 4'b0000, '0, 16'd0));
        vecs.push_back(mk(4'b0100, 4'b0100, {6'd0,6'd7,6'd0,6'd0}, {8'h0,8'h77,8'h0,8'h0}, 4'b0100, 4'b0010, 4'b0010, {8'h0,8'h0,8'hAA,8'h0}, 16'd0));
        vecs.push_back(mk(4'b1000, 4'b1000, {6'd3,6'd0,6'd0,6'd0}, {8'h33,8'h0,8'h0,8'h0}, 4'b1000, 4'b0100, 4'b0000, '0, 16'd0));
        vecs.push_back(mk(4'b0011, 4'b0001, {6'd0,6'd0,6'd3,6'd3}, {8'h0,8'h0,8'h0,8'hC3}, 4'b0001, 4'b1000, 4'b0000, '0, 16'd0));
        vecs.push_back(mk(4'b0010, 4'b0000, {6'd0,6'd0,6'd3,6'd0}, '0,                     4'b0010, 4'b0001, 4'b0001, {8'h0,8'h0,8'h0,8'h33}, 16'd1));
        vecs.push_back(mk(4'b1100, 4'b0000, {6'd7,6'd7,6'd0,6'd0}, '0,                     4'b1100, 4'b0010, 4'b0010, {8'h0,8'h0,8'hC3,8'h0}, 16'd1));
        vecs.push_back(mk(4'b0000, 4'b0000, '0,                    '0,                     4'b0000, 4'b1100, 4'b1100, {8'h77,8'h77,8'h0,8'h0}, 16'd1));
        vecs.push_back(mk(4'b1111, 4'b0000, {6'd20,6'd7,6'd3,6'd5}, '0,                    4'b0011, 4'b0000, 4'b0000, '0, 16'd1));
        vecs.push_back(mk(4'b1111, 4'b0000, {6'd20,6'd7,6'd3,6'd5}, '0,                    4'b1100, 4'b0011, 4'b0011, {8'h0,8'h0,8'hC3,8'hAA}, 16'd1));
        vecs.push_back(mk(4'b1111, 4'b0000, {6'd20,6'd7,6'd3,6'd5}, '0,                    4'b0011, 4'b1100, 4'b0100, {8'h0,8'h77,8'h0,8'h0}, 16'd1));
        vecs.push_back(mk(4'b1111, 4'b0000, {6'd20,6'd7,6'd3,6'd5}, '0,                    4'b1100, 4'b0011, 4'b0011, {8'h0,8'h0,8'hC3,8'hAA}, 16'd1));
        vecs.push_back(mk(4'b0000, 4'b0000, '0,                    '0,                     4'b0000, 4'b1100, 4'b0100, {8'h0,8'h77,8'h0,8'h0}, 16'd1));
        vecs.push_back(mk(4'b0011, 4'b0010, {6'd0,6'd0,6'd5,6'd5}, {8'h0,8'h0,8'h55,8'h0}, 4'b0001, 4'b0000, 4'b0000, '0, 16'd1));
        vecs.push_back(mk(4'b0110, 4'b0010, {6'd0,6'd7,6'd5,6'd0}, {8'h0,8'h0,8'h55,8'h0}, 4'b0110, 4'b0001, 4'b0001, {8'h0,8'h0,8'h0,8'hAA}, 16'd2));
        vecs.push_back(mk(4'b1001, 4'b0000, {6'd5,6'd0,6'd0,6'd5}, '0,                     4'b1001, 4'b0110, 4'b0110, {8'h0,8'h77,8'hAA,8'h0}, 16'd2));
        vecs.push_back(mk(4'b0000, 4'b0000, '0,                    '0,                     4'b0000, 4'b1001, 4'b1001, {8'h55,8'h0,8'h0,8'h55}, 16'd2));
        vecs.push_back(mk(4'b1110, 4'b0010, {6'd20,6'd9,6'd9,6'd0}, {8'h0,8'h0,8'h99,8'h0}, 4'b0010, 4'b0000, 4'b0000, '0, 16'd2));
        vecs.push_back(mk(4'b0000, 4'b0000, '0,                    '0,                     4'b0000, 4'b0010, 4'b0000, '0, 16'd3));

        // Reset: requests present but must not be granted
        rst_n = 1'b0;
        drive(4'b1111, 4'b1111, {6'd40,6'd40,6'd40,6'd40}, {8'hEE,8'hEE,8'hEE,8'hEE});
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(bus.req_ready), 64'h0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive('0, '0, '0, '0);
        @(negedge clk);
        chk("post_rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        chk("post_rst_stall", 64'(stall_cnt), 64'h0);
        for (int i = 0; i < NR; i++) chk($sformatf("post_rst_rdata%0d", i), rdata(i), 64'h0);

        for (int n = 0; n < vecs.size(); n++) begin
            @(posedge clk); #1;
            drive(vecs[n].valid, vecs[n].wen, vecs[n].addr, vecs[n].wdata);
            @(negedge clk);
            chk($sformatf("v%0d_ready", n), 64'(bus.req_ready), 64'(vecs[n].exp_ready));
            chk($sformatf("v%0d_rsp_valid", n), 64'(bus.rsp_valid), 64'(vecs[n].exp_rsp));
            chk($sformatf("v%0d_stall", n), 64'(stall_cnt), 64'(vecs[n].exp_stall));
            for (int i = 0; i < NR; i++) begin
                if (!vecs[n].exp_rsp[i])
                    chk($sformatf("v%0d_rdata%0d_idle", n, i), rdata(i), 64'h0);
                else if (vecs[n].chk_rd[i])
                    chk($sformatf("v%0d_rdata%0d", n, i), rdata(i), 64'(vecs[n].exp_rd[i]));
            end
        end

        // Reset the cycle after a grant: response dropped, RAM write blocked
        @(posedge clk); #1;
        drive(4'b0100, 4'b0000, {6'd0,6'd7,6'd0,6'd0}, '0);
        @(negedge clk);
        chk("rstmid_grant", 64'(bus.req_ready), 64'h4);
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive(4'b0001, 4'b0001, {6'd0,6'd0,6'd0,6'd7}, {8'h0,8'h0,8'h0,8'h11});
        @(negedge clk);
        chk("rstmid_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        chk("rstmid_rdata2", rdata(2), 64'h0);
        chk("rstmid_ready", 64'(bus.req_ready), 64'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstmid_stall", 64'(stall_cnt), 64'h0);
        chk("rstmid_rsp_valid2", 64'(bus.rsp_valid), 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(4'b0001, 4'b0000, {6'd0,6'd0,6'd0,6'd7}, '0);
        @(negedge clk);
        chk("rstrel_ready", 64'(bus.req_ready), 64'h1);
        chk("rstrel_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        @(posedge clk); #1;
        drive('0, '0, '0, '0);
        @(negedge clk);
        chk("rstrel_rsp", 64'(bus.rsp_valid), 64'h1);
        chk("rstrel_rdata0", rdata(0), 64'h77);

        // Two writers on one address conflict every cycle
        @(posedge clk); #1;
        drive(4'b0011, 4'b0011, {6'd0,6'd0,6'd63,6'd63}, {8'h0,8'h0,8'h02,8'h01});
        repeat (65534) @(posedge clk);
        @(negedge clk);
        chk("stall_near_max", 64'(stall_cnt), 64'hFFFE);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("stall_saturated", 64'(stall_cnt), 64'hFFFF);
        @(posedge clk); #1;
        drive('0, '0, '0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
